// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS datapath blocks.
package mips_pkg;

    localparam int MULDIV_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    // True for DIV/DIVU.
    function automatic logic op_is_div(input logic [1:0] o);
        return (muldiv_op_t'(o) == OP_DIV) || (muldiv_op_t'(o) == OP_DIVU);
    endfunction

    // True for the two's-complement variants MULT/DIV.
    function automatic logic op_is_signed(input logic [1:0] o);
        return (muldiv_op_t'(o) == OP_MULT) || (muldiv_op_t'(o) == OP_DIV);
    endfunction

endpackage

// File: rtl/sign_mag_conv.sv
// sign_mag_conv: combinational conditional two's-complement negate.
// Driving neg_en with the operand sign bit yields its magnitude; driving it
// with a recorded result sign restores the signed result.
module sign_mag_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg_en,
    output logic [W-1:0] dout
);

    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude for the iteration datapath.
    assign dout = neg_en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU for the multicycle MIPS datapath.
// Radix-2 shift-add multiply and restoring divide, one bit per clock over
// WIDTH iterations. Operands are reduced to magnitudes on start; the result
// sign is fixed up on the final iteration as HI/LO are loaded.
// Optional feature: define MULDIV_HILO_WR_EN to add the MTHI/MTLO write port
// (hi_wr, lo_wr, wr_data).
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MULDIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_HILO_WR_EN
    ,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    muldiv_state_t     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              op_div_q, op_div_d;
    logic              neg_res_q, neg_res_d;   // product / quotient sign
    logic              neg_rem_q, neg_rem_d;   // remainder follows dividend
    logic [WIDTH-1:0]  mcand_q, mcand_d;       // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] work_q, work_d;        // {hi half, lo half} working pair
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_zero_q, div_zero_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    // Operand decode and magnitude conversion on the raw inputs
    logic             in_div, in_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign in_div    = op_is_div(op);
    assign in_signed = op_is_signed(op);
    assign a_neg     = in_signed & a_in[WIDTH-1];
    assign b_neg     = in_signed & b_in[WIDTH-1];

    sign_mag_conv #(.W(WIDTH)) u_abs_a (.din(a_in), .neg_en(a_neg), .dout(a_mag));
    sign_mag_conv #(.W(WIDTH)) u_abs_b (.din(b_in), .neg_en(b_neg), .dout(b_mag));

    // One radix-2 step of either the shift-add multiply or restoring divide
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next;

    always_comb begin
        mul_add  = work_q[0] ? mcand_q : {WIDTH{1'b0}};
        mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        mul_next = {mul_sum, work_q[WIDTH-1:1]};
        // Partial remainder shifted left with the next dividend bit, minus divisor
        div_diff = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
        div_next = div_diff[WIDTH] ? {work_q[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        step_next = op_div_q ? div_next : mul_next;
    end

    // Sign fix-up applied to the value produced by the final step
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    sign_mag_conv #(.W(2*WIDTH)) u_fix_prod (
        .din(step_next), .neg_en(neg_res_q), .dout(prod_fix));
    sign_mag_conv #(.W(WIDTH)) u_fix_quo (
        .din(step_next[WIDTH-1:0]), .neg_en(neg_res_q), .dout(quo_fix));
    sign_mag_conv #(.W(WIDTH)) u_fix_rem (
        .din(step_next[2*WIDTH-1:WIDTH]), .neg_en(neg_rem_q), .dout(rem_fix));

    assign res_hi = op_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo = op_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    // Next-state logic: start acceptance, iteration, completion, HI/LO writes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        mcand_d    = mcand_q;
        work_d     = work_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
`ifdef MULDIV_HILO_WR_EN
                // MTHI/MTLO land even when an operation starts on the same edge
                if (hi_wr) hi_d = wr_data;
                if (lo_wr) lo_d = wr_data;
`endif
                if (start) begin
                    if (in_div && (b_in == '0)) begin
                        // Divide by zero completes immediately and leaves HI/LO alone
                        state_d    = DONE;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        op_div_d  = in_div;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        mcand_d   = in_div ? b_mag : a_mag;
                        work_d    = {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
                    end
                end
            end
            BUSY: begin
                work_d = step_next;
                cnt_d  = cnt_q + CW'(1);
                busy_d = 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            mcand_q    <= '0;
            work_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            mcand_q    <= mcand_d;
            work_q     <= work_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit. Stimulus pushes the
// expected HI/LO/div_zero from an arithmetic reference model; a monitor pops
// and compares on every done pulse.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic         clk, reset, start;
    logic [1:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_HILO_WR_EN
    logic         hi_wr, lo_wr;
    logic [W-1:0] wr_data;
`endif

    exp_t         exp_q[$];
    logic [W-1:0] m_hi, m_lo;
    int           n_checks, n_fail;

    mult_div_unit #(.WIDTH(W)) dut (
`ifdef MULDIV_HILO_WR_EN
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
`endif
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; SV / and % truncate toward zero
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [W-1:0] ph,
                                   input logic [W-1:0] pl);
        exp_t e;
        logic signed [63:0] sa, sb, sr;
        logic [63:0] ua, ub, ur;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        e.dz = 1'b0;
        e.hi = ph;
        e.lo = pl;
        case (o)
            MULT:  begin sr = sa * sb; e.hi = sr[63:32]; e.lo = sr[31:0]; end
            MULTU: begin ur = ua * ub; e.hi = ur[63:32]; e.lo = ur[31:0]; end
            default: begin
                if (b == 0) e.dz = 1'b1;
                else if (o == DIV) begin
                    sr = sa / sb; e.lo = sr[31:0];
                    sr = sa % sb; e.hi = sr[31:0];
                end else begin
                    ur = ua / ub; e.lo = ur[31:0];
                    ur = ua % ub; e.hi = ur[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no outstanding op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_hi", hi, e.hi);
                chk("mon_lo", lo, e.lo);
                chk("mon_div_zero", div_zero, e.dz);
            end
        end
    end

    // Issue one operation (called at #1 after an edge) and wait for done.
    // Returns #1 after the edge that raised done, i.e. inside the DONE cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int n, nb, lat;
        e = model(o, a, b, m_hi, m_lo);
        m_hi = e.hi;
        m_lo = e.lo;
        exp_q.push_back(e);
        lat = e.dz ? 1 : W + 1;
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Operand inputs are free to change after the start edge
        op = 2'($urandom); a_in = $urandom; b_in = $urandom;
        n = 1; nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        chk("busy_cycles", nb, lat - 1);
        chk("busy_low_at_done", busy, 0);
    endtask

    initial begin
        int ndone;
        n_checks = 0; n_fail = 0;
        reset = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
        m_hi = '0; m_lo = '0;
`ifdef MULDIV_HILO_WR_EN
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
`endif
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // 1: MULTU max*max
        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("t1_hi", hi, 32'hFFFFFFFE);
        chk("t1_lo", lo, 32'h00000001);

        // 2: MULT -3*7, then back-to-back start from DONE
        repeat (2) @(posedge clk);
        #1;
        do_op(MULT, 32'hFFFFFFFD, 32'd7);
        chk("t2_hi", hi, 32'hFFFFFFFF);
        chk("t2_lo", lo, 32'hFFFFFFEB);
        do_op(MULT, 32'd2, 32'd3);
        chk("t2b_hi", hi, 32'd0);
        chk("t2b_lo", lo, 32'd6);

        // 3: divides including the signed overflow corner
        do_op(DIV, 32'hFFFFFFF9, 32'd2);
        chk("t3_lo", lo, 32'hFFFFFFFD);
        chk("t3_hi", hi, 32'hFFFFFFFF);
        do_op(DIVU, 32'd7, 32'd2);
        chk("t3b_lo", lo, 32'd3);
        chk("t3b_hi", hi, 32'd1);
        do_op(DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("t3c_lo", lo, 32'h80000000);
        chk("t3c_hi", hi, 32'd0);

        // 4: divide by zero keeps HI/LO
        do_op(MULT, 32'd5, 32'd5);
        do_op(DIVU, 32'd1234, 32'd0);
        chk("t4_div_zero", div_zero, 1);
        chk("t4_hi", hi, 32'd0);
        chk("t4_lo", lo, 32'd25);

        // 5: ignored start mid-operation, then reset mid-operation
        op = MULTU; a_in = 32'd100; b_in = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op = DIVU; b_in = 32'd0; start = 1'b1;   // sampled at iteration 5
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_busy_after_ignored_start", busy, 1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_hi", hi, 0);
        chk("t5_lo", lo, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk); reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);

`ifdef MULDIV_HILO_WR_EN
        // 6: MTHI in IDLE, ignored in BUSY, MTLO alongside a divide-by-zero start
        hi_wr = 1'b1; wr_data = 32'h12345678;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        chk("t6_hi_write", hi, 32'h12345678);
        m_hi = 32'h12345678;
        begin
            exp_t e;
            int n;
            e = model(MULTU, 32'h00010000, 32'h00030000, m_hi, m_lo);
            m_hi = e.hi; m_lo = e.lo;
            exp_q.push_back(e);
            op = MULTU; a_in = 32'h00010000; b_in = 32'h00030000; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            hi_wr = 1'b1; wr_data = 32'hDEADBEEF;
            @(posedge clk); #1;
            hi_wr = 1'b0;
            n = 2;
            while (!done && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6_latency", n, W + 1);
            chk("t6_hi_busy_write_ignored", hi, 32'd3);
        end
        lo_wr = 1'b1; wr_data = 32'h00005A5A;
        m_lo = 32'h00005A5A;
        exp_q.push_back('{hi: m_hi, lo: 32'h00005A5A, dz: 1'b1});
        op = DIVU; a_in = 32'd9; b_in = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lo_wr = 1'b0;
        chk("t6_wr_and_start_done", done, 1);
        chk("t6_wr_and_start_lo", lo, 32'h00005A5A);
`endif

        // Randomized operations with corner operands and idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a, b;
            int           sel;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: begin a = -$urandom_range(1, 1000); b = $urandom_range(1, 17); end
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            if (!done && !busy) begin end
            do_op(o, a, b);
        end

        ndone = 0;
        while (exp_q.size() != 0 && ndone < 50) begin
            @(posedge clk); #1;
            ndone++;
        end
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
